fp_mul_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754-style floating-point multiplier; next generation of the team's combinational single-precision multiplier.
- Generalised exponent/mantissa widths, 3-stage pipeline, valid/ready handshake on both sides.
- Adds correct rounding, carry-out of rounding, underflow handling and exception flags.
- Sits between the operand issue logic and the result writeback path.

---
 rtl/fp_mul_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage IEEE-754-style multiplier, valid/ready on both sides.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/in_a/in_b,
//   out_valid/out_ready/out_result/out_flags {invalid,overflow,underflow,inexact}.
// Params: EXP_W, MAN_W. Macro FP_MUL_RNE_EN: round-nearest-even, else truncate.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [3:0]               out_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int XW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic signed [XW-1:0] BIAS_S = XW'(BIAS);
  localparam logic signed [XW-1:0] EMAX_S = XW'(EMAX);

  typedef enum logic [1:0] {
    K_NORM, K_ZERO, K_INF, K_NAN
  } kind_e;

  typedef struct packed {
    logic               sgn;
    kind_e              kind;
    logic               inv;
    logic signed [XW-1:0] exp;
    logic [SW-1:0]      ma;
    logic [SW-1:0]      mb;
  } s1_t;

  typedef struct packed {
    logic               sgn;
    kind_e              kind;
    logic               inv;
    logic signed [XW-1:0] exp;
    logic [PW-1:0]      prod;
  } s2_t;

  logic advance;
  logic s1_v_q, s2_v_q, out_v_q;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic [W-1:0] res_d, res_q;
  logic [3:0]   flg_d, flg_q;

  // Whole pipe moves together; bubbles hold too.
  assign advance    = !out_v_q || out_ready;
  assign in_ready   = advance;
  assign out_valid  = out_v_q;
  assign out_result = res_q;
  assign out_flags  = flg_q;

  // S1: unpack, classify, sign, exponent sum
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  always_comb begin
    ea     = in_a[W-2:MAN_W];
    eb     = in_b[W-2:MAN_W];
    fa     = in_a[MAN_W-1:0];
    fb     = in_b[MAN_W-1:0];
    a_nan  = (&ea) && (|fa);
    b_nan  = (&eb) && (|fb);
    a_inf  = (&ea) && !(|fa);
    b_inf  = (&eb) && !(|fb);
    // exp==0 covers subnormals: flushed to zero
    a_zero = !(|ea);
    b_zero = !(|eb);

    s1_d      = '0;
    s1_d.sgn  = in_a[W-1] ^ in_b[W-1];
    s1_d.ma   = {1'b1, fa};
    s1_d.mb   = {1'b1, fb};
    s1_d.exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
    s1_d.kind = K_NORM;
    if (a_nan || b_nan) begin
      s1_d.kind = K_NAN;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      s1_d.kind = K_NAN;
      s1_d.inv  = 1'b1;
    end else if (a_inf || b_inf) begin
      s1_d.kind = K_INF;
    end else if (a_zero || b_zero) begin
      s1_d.kind = K_ZERO;
    end
  end

  // S2: significand multiply
  always_comb begin
    s2_d.sgn  = s1_q.sgn;
    s2_d.kind = s1_q.kind;
    s2_d.inv  = s1_q.inv;
    s2_d.exp  = s1_q.exp;
    s2_d.prod = PW'(s1_q.ma) * PW'(s1_q.mb);
  end

  // S3: normalise, round, pack
  logic               msb, guard, sticky, rnd, carry;
  logic [PW-1:0]      shf;
  logic [SW-1:0]      sig;
  logic [SW:0]        sum;
  logic [MAN_W-1:0]   frac;
  logic signed [XW-1:0] e_n, e_r;

  always_comb begin
    msb    = s2_q.prod[PW-1];
    shf    = msb ? s2_q.prod : (s2_q.prod << 1);
    e_n    = s2_q.exp + $signed({{(XW-1){1'b0}}, msb});
    sig    = shf[PW-1 -: SW];
    guard  = shf[MAN_W];
    sticky = |shf[MAN_W-1:0];
`ifdef FP_MUL_RNE_EN
    rnd    = guard && (sticky || sig[0]);
`else
    rnd    = 1'b0;
`endif
    sum    = {1'b0, sig} + {{SW{1'b0}}, rnd};
    // Carry to 2.0 renormalises; the fraction is then zero.
    carry  = sum[SW];
    frac   = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
    e_r    = e_n + $signed({{(XW-1){1'b0}}, carry});

    res_d = {s2_q.sgn, e_r[EXP_W-1:0], frac};
    flg_d = {3'b000, guard || sticky};
    unique case (s2_q.kind)
      K_NAN: begin
        res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flg_d = {s2_q.inv, 3'b000};
      end
      K_INF: begin
        res_d = {s2_q.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flg_d = 4'b0000;
      end
      K_ZERO: begin
        res_d = {s2_q.sgn, {(W-1){1'b0}}};
        flg_d = 4'b0000;
      end
      default: begin
        if (!e_r[XW-1] && (e_r >= EMAX_S)) begin
          res_d = {s2_q.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flg_d = 4'b0101;
        end else if (e_r[XW-1] || (e_r == '0)) begin
          res_d = {s2_q.sgn, {(W-1){1'b0}}};
          flg_d = 4'b0011;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      out_v_q <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else if (advance) begin
      s1_v_q  <= in_valid;
      s2_v_q  <= s1_v_q;
      out_v_q <= s2_v_q;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  // Datapath stage registers need no reset; valids qualify them.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed vectors, queue scoreboard, decoupled monitor.
// Covers reset, specials, rounding, overflow/underflow, stall, mid-op reset.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          stamp;
    bit          lat;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [31:0] a, b, r;
    logic [3:0]  f;
  } vec_t;
  vec_t vecs[$];
  vec_t burst[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: pops on each transfer, checks stability while stalled.
  logic [31:0] held_r;
  logic [3:0]  held_f;
  bit          held = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (held) begin
          chk("stall_result", out_result, held_r);
          chk("stall_flags", 32'(out_flags), 32'(held_f));
        end
        if (out_ready) begin
          held = 0;
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious: got %h with empty queue", out_result);
          end else begin
            e = sbq.pop_front();
            chk("result", out_result, e.r);
            chk("flags", 32'(out_flags), 32'(e.f));
            if (e.lat) chk("latency", 32'(cyc - e.stamp), 32'd3);
          end
        end else begin
          held   = 1;
          held_r = out_result;
          held_f = out_flags;
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic send(logic [31:0] a, logic [31:0] b,
                      logic [31:0] r, logic [3:0] f, bit lat);
    bit acc = 0;
    int n = 0;
    int st = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    forever begin
      #1;
      acc = in_ready;
      st = cyc;
      @(posedge clk);
      if (acc) break;
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got in_ready 0 want 1");
        break;
      end
      @(negedge clk);
    end
    if (acc) begin
      e.r = r;
      e.f = f;
      e.stamp = st;
      e.lat = lat;
      sbq.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d left want 0", sbq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  logic [31:0] r_g, r_t, r_e;

  initial begin
`ifdef FP_MUL_RNE_EN
    r_g = 32'h3FC00003;
    r_t = 32'h3FC00002;
    r_e = 32'h40100001;
`else
    r_g = 32'h3FC00002;
    r_t = 32'h3FC00001;
    r_e = 32'h40100000;
`endif
    vecs.push_back('{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000});
    vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000});
    vecs.push_back('{32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000});
    vecs.push_back('{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b0000});
    vecs.push_back('{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101});
    vecs.push_back('{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011});
    vecs.push_back('{32'h3FC00001, 32'h3F800001, r_g, 4'b0001});
    vecs.push_back('{32'h3F800001, 32'h3FC00000, r_t, 4'b0001});
    vecs.push_back('{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001});
    vecs.push_back('{32'h3FC00001, 32'h3FC00000, r_e, 4'b0001});
    vecs.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000});
    vecs.push_back('{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000});
    vecs.push_back('{32'h40400000, 32'hC0000000, 32'hC0C00000, 4'b0000});

    burst.push_back('{32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000});
    burst.push_back('{32'h40000000, 32'h40000000, 32'h40800000, 4'b0000});
    burst.push_back('{32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000});
    burst.push_back('{32'h40800000, 32'h3F000000, 32'h40000000, 4'b0000});
    burst.push_back('{32'hBF800000, 32'h40400000, 32'hC0400000, 4'b0000});
    burst.push_back('{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors back-to-back, consumer always ready
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].f, 1'b1);
    idle();
    drain();

    // Burst with consumer stalled from cycle 2
    fork
      begin
        foreach (burst[i])
          send(burst[i].a, burst[i].b, burst[i].r, burst[i].f, 1'b0);
        idle();
      end
      begin
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset one cycle after two inputs are accepted
    send(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 1'b0);
    send(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
